// File: rtl/pac_pkg.sv
// Shared types and constants for the Pac-Man motion slice.
// Direction encoding, screen geometry, keyboard codes and address helper.
package pac_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROBE_REQ,
    S_PROBE_CUR,
    S_COMMIT
  } state_t;

  localparam int SPRITE_SZ = 16;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int PROBE_LEN = 17;

  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;

  function automatic dir_t key_to_dir(
    input logic [7:0] key
  );
    dir_t d;
    case (key)
      KEY_UP:    d = DIR_UP;
      KEY_DOWN:  d = DIR_DOWN;
      KEY_LEFT:  d = DIR_LEFT;
      KEY_RIGHT: d = DIR_RIGHT;
      default:   d = DIR_NONE;
    endcase
    return d;
  endfunction

  // x + y*640 without a multiplier
  function automatic logic [18:0] pix_addr(
    input logic [9:0] x,
    input logic [9:0] y
  );
    logic [18:0] yw;
    yw = {9'd0, y};
    return (yw << 9) + (yw << 7) + {9'd0, x};
  endfunction

endpackage

// File: rtl/pac_edge_prober.sv
// Walks the 16 pixels on the sprite's leading edge and ORs the wall bits.
// One start pulse gives a fixed 17-cycle probe ending with done.
module pac_edge_prober
  import pac_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  dir_t        dir,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        wall_bit,
  output logic [18:0] wall_addr,
  output logic        done,
  output logic        blocked
);

  logic [4:0]  cnt_q, cnt_d;
  logic        active_q, active_d;
  logic        acc_q, acc_d;
  logic        oob;
  logic [9:0]  px, py;
  logic [9:0]  idx;
  logic [10:0] x11, y11;

  assign idx = {6'd0, cnt_q[3:0]};
  assign x11 = {1'b0, pos_x};
  assign y11 = {1'b0, pos_y};

  always_comb begin
    oob = 1'b0;
    px  = pos_x;
    py  = pos_y;
    case (dir)
      DIR_UP: begin
        oob = (pos_y == 10'd0);
        px  = pos_x + idx;
        py  = pos_y - 10'd1;
      end
      DIR_DOWN: begin
        oob = (y11 + 11'(SPRITE_SZ)) > 11'(SCREEN_H - 1);
        px  = pos_x + idx;
        py  = pos_y + 10'(SPRITE_SZ);
      end
      DIR_LEFT: begin
        oob = (pos_x == 10'd0);
        px  = pos_x - 10'd1;
        py  = pos_y + idx;
      end
      DIR_RIGHT: begin
        oob = (x11 + 11'(SPRITE_SZ)) > 11'(SCREEN_W - 1);
        px  = pos_x + 10'(SPRITE_SZ);
        py  = pos_y + idx;
      end
      default: ;
    endcase
  end

  assign done    = active_q && (cnt_q == 5'(PROBE_LEN - 1));
  // last sample arrives in the done cycle, so fold it in directly
  assign blocked = oob | acc_q | wall_bit;

  assign wall_addr = (active_q && !cnt_q[4] && !oob) ?
                     pix_addr(px, py) : '0;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    acc_d    = acc_q;
    if (start) begin
      cnt_d    = '0;
      active_d = 1'b1;
      acc_d    = 1'b0;
    end else if (active_q) begin
      if (cnt_q != 5'd0) acc_d = acc_q | wall_bit;
      if (done) active_d = 1'b0;
      else      cnt_d    = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      acc_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/pac_motion.sv
// Per-frame Pac-Man movement controller: key latch, wall probe FSM,
// position registers and sprite hit/offset for the color mapper.
module pac_motion
  import pac_pkg::*;
#(
  parameter int RESET_X = 312,
  parameter int RESET_Y = 232
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [18:0] wall_addr,
  input  logic        wall_bit,
  output logic        is_pac,
  output logic [9:0]  PacX,
  output logic [9:0]  PacY,
  output logic [9:0]  PosX,
  output logic [9:0]  PosY,
  output logic [2:0]  cur_dir,
  output logic        busy
);

  state_t     state_q, state_d;
  dir_t       req_dir_q, req_dir_d;
  dir_t       cur_dir_q, cur_dir_d;
  dir_t       snap_req_q, snap_req_d;
  dir_t       snap_cur_q, snap_cur_d;
  dir_t       key_dir, probe_dir;
  logic       move_q, move_d;
  logic [9:0] pos_x_q, pos_x_d;
  logic [9:0] pos_y_q, pos_y_d;
  logic       fr_q, fr_d1_q, edge_q;
  logic       start, done, blocked;

  assign key_dir   = key_to_dir(keycode);
  assign probe_dir = (state_q == S_PROBE_CUR) ? snap_cur_q : snap_req_q;

  pac_edge_prober u_prober (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .start     (start),
    .dir       (probe_dir),
    .pos_x     (pos_x_q),
    .pos_y     (pos_y_q),
    .wall_bit  (wall_bit),
    .wall_addr (wall_addr),
    .done      (done),
    .blocked   (blocked)
  );

  always_comb begin
    state_d    = state_q;
    req_dir_d  = (key_dir != DIR_NONE) ? key_dir : req_dir_q;
    cur_dir_d  = cur_dir_q;
    snap_req_d = snap_req_q;
    snap_cur_d = snap_cur_q;
    move_d     = move_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    start      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (edge_q) begin
          snap_req_d = req_dir_q;
          snap_cur_d = cur_dir_q;
          move_d     = 1'b0;
          if (req_dir_q != DIR_NONE) begin
            state_d = S_PROBE_REQ;
            start   = 1'b1;
          end else if (cur_dir_q != DIR_NONE) begin
            state_d = S_PROBE_CUR;
            start   = 1'b1;
          end
        end
      end
      S_PROBE_REQ: begin
        if (done) begin
          if (!blocked) begin
            cur_dir_d = snap_req_q;
            move_d    = 1'b1;
            state_d   = S_COMMIT;
          end else if (snap_cur_q != DIR_NONE &&
                       snap_cur_q != snap_req_q) begin
            state_d = S_PROBE_CUR;
            start   = 1'b1;
          end else begin
            state_d = S_COMMIT;
            if (snap_cur_q == snap_req_q) cur_dir_d = DIR_NONE;
          end
        end
      end
      S_PROBE_CUR: begin
        if (done) begin
          state_d = S_COMMIT;
          if (!blocked) move_d    = 1'b1;
          else          cur_dir_d = DIR_NONE;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (move_q) begin
          case (cur_dir_q)
            DIR_UP:    pos_y_d = pos_y_q - 10'd1;
            DIR_DOWN:  pos_y_d = pos_y_q + 10'd1;
            DIR_LEFT:  pos_x_d = pos_x_q - 10'd1;
            DIR_RIGHT: pos_x_d = pos_x_q + 10'd1;
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      req_dir_q  <= DIR_NONE;
      cur_dir_q  <= DIR_NONE;
      snap_req_q <= DIR_NONE;
      snap_cur_q <= DIR_NONE;
      move_q     <= 1'b0;
      pos_x_q    <= 10'(RESET_X);
      pos_y_q    <= 10'(RESET_Y);
      fr_q       <= 1'b0;
      fr_d1_q    <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_dir_q  <= req_dir_d;
      cur_dir_q  <= cur_dir_d;
      snap_req_q <= snap_req_d;
      snap_cur_q <= snap_cur_d;
      move_q     <= move_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      fr_q       <= frame_clk;
      fr_d1_q    <= fr_q;
      edge_q     <= fr_q & ~fr_d1_q;
    end
  end

  logic [10:0] dx_rel, dy_rel;

  assign dx_rel = {1'b0, DrawX} - {1'b0, pos_x_q};
  assign dy_rel = {1'b0, DrawY} - {1'b0, pos_y_q};

  assign is_pac = (DrawX >= pos_x_q) && (DrawY >= pos_y_q) &&
                  (dx_rel < 11'(SPRITE_SZ)) &&
                  (dy_rel < 11'(SPRITE_SZ));

  assign PacX    = is_pac ? dx_rel[9:0] : '0;
  assign PacY    = is_pac ? dy_rel[9:0] : '0;
  assign PosX    = pos_x_q;
  assign PosY    = pos_y_q;
  assign cur_dir = cur_dir_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_pac_motion.sv
// Self-checking bench for pac_motion: sprite hit table plus
// scoreboarded frame updates against a behavioural maze.
module tb_pac_motion;
  import pac_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic [7:0]  keycode = 8'h00;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        wall_bit = 1'b0;
  logic [18:0] wall_addr;
  logic        is_pac;
  logic [9:0]  PacX, PacY, PosX, PosY;
  logic [2:0]  cur_dir;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  bit maze [int];

  typedef struct {
    logic [9:0] dx;
    logic [9:0] dy;
    logic       ip;
    logic [9:0] px;
    logic [9:0] py;
  } vec_t;

  typedef struct {
    string name;
    int    lat;
    int    x;
    int    y;
    int    dir;
  } exp_t;

  exp_t sb[$];

  pac_motion #(.RESET_X(312), .RESET_Y(232)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .keycode   (keycode),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .wall_addr (wall_addr),
    .wall_bit  (wall_bit),
    .is_pac    (is_pac),
    .PacX      (PacX),
    .PacY      (PacY),
    .PosX      (PosX),
    .PosY      (PosY),
    .cur_dir   (cur_dir),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  // one-cycle read latency maze RAM
  always @(posedge Clk)
    wall_bit <= maze.exists(int'(wall_addr)) ? 1'b1 : 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    @(posedge Clk); #1;
    keycode = 8'h00;
    @(posedge Clk); #1;
  endtask

  task automatic pulse(input string name, input bit chk_addr,
                       output int got, output bit nz);
    int x0, y0;
    bit saw;
    x0 = int'(PosX);
    y0 = int'(PosY);
    got = -1;
    saw = 1'b0;
    nz = 1'b0;
    frame_clk = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(posedge Clk); #1;
      if (n == 4) frame_clk = 1'b0;
      if (wall_addr != '0) nz = 1'b1;
      if (chk_addr && n >= 3 && n <= 18)
        check($sformatf("%s_addr%0d", name, n - 3), 32'(wall_addr),
              32'((y0 + n - 3) * 640 + x0 + 16));
      if (busy) saw = 1'b1;
      if (saw && !busy) begin
        got = n;
        break;
      end
      if (!saw && n >= 30) begin
        got = 0;
        break;
      end
    end
    frame_clk = 1'b0;
  endtask

  // lat counts clocks from frame_clk rise until busy is low again
  task automatic frame(input string name, input int lat, input int x,
                       input int y, input int dir, input bit chk_addr,
                       input bit want_zero_addr);
    exp_t e, r;
    int got;
    bit nz;
    e.name = name;
    e.lat = lat;
    e.x = x;
    e.y = y;
    e.dir = dir;
    sb.push_back(e);
    pulse(name, chk_addr, got, nz);
    r = sb.pop_front();
    check({r.name, "_lat"}, got, r.lat);
    check({r.name, "_posx"}, 32'(PosX), r.x);
    check({r.name, "_posy"}, 32'(PosY), r.y);
    check({r.name, "_dir"}, 32'(cur_dir), r.dir);
    if (want_zero_addr) check({r.name, "_addr_zero"}, 32'(nz), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int got;
    bit nz;
    vt[0] = '{10'd318, 10'd240, 1'b1, 10'd6,  10'd8};
    vt[1] = '{10'd312, 10'd232, 1'b1, 10'd0,  10'd0};
    vt[2] = '{10'd327, 10'd247, 1'b1, 10'd15, 10'd15};
    vt[3] = '{10'd328, 10'd240, 1'b0, 10'd0,  10'd0};
    vt[4] = '{10'd311, 10'd240, 1'b0, 10'd0,  10'd0};
    vt[5] = '{10'd318, 10'd248, 1'b0, 10'd0,  10'd0};
    vt[6] = '{10'd318, 10'd231, 1'b0, 10'd0,  10'd0};
    vt[7] = '{10'd0,   10'd0,   1'b0, 10'd0,  10'd0};

    repeat (2) @(posedge Clk);
    #1;
    check("rst_posx", 32'(PosX), 312);
    check("rst_posy", 32'(PosY), 232);
    check("rst_dir", 32'(cur_dir), 32'(DIR_NONE));
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(wall_addr), 0);
    Reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      DrawX = vt[i].dx;
      DrawY = vt[i].dy;
      #1;
      check($sformatf("vec%0d_is_pac", i), 32'(is_pac), 32'(vt[i].ip));
      check($sformatf("vec%0d_pacx", i), 32'(PacX), 32'(vt[i].px));
      check($sformatf("vec%0d_pacy", i), 32'(PacY), 32'(vt[i].py));
    end

    press(KEY_RIGHT);
    frame("open", 21, 313, 232, 32'(DIR_RIGHT), 1'b1, 1'b0);

    press(KEY_UP);
    maze[231 * 640 + 315] = 1'b1;
    frame("turn", 38, 314, 232, 32'(DIR_RIGHT), 1'b0, 1'b0);

    maze.delete();
    press(KEY_DOWN);
    frame("down", 21, 314, 233, 32'(DIR_DOWN), 1'b0, 1'b0);

    for (int x = 300; x < 340; x++) maze[249 * 640 + x] = 1'b1;
    frame("stop", 21, 314, 233, 32'(DIR_NONE), 1'b0, 1'b0);
    frame("stay", 21, 314, 233, 32'(DIR_NONE), 1'b0, 1'b0);
    maze.delete();

    frame_clk = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      @(posedge Clk); #1;
      if (n == 4) frame_clk = 1'b0;
    end
    check("mid_busy", 32'(busy), 1);
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_posx", 32'(PosX), 312);
    check("mid_rst_posy", 32'(PosY), 232);
    check("mid_rst_dir", 32'(cur_dir), 32'(DIR_NONE));
    check("mid_rst_addr", 32'(wall_addr), 0);
    Reset_n = 1'b1;
    DrawX = 10'd318;
    DrawY = 10'd240;
    #1;
    check("mid_is_pac", 32'(is_pac), 1);
    check("mid_pacx", 32'(PacX), 6);
    check("mid_pacy", 32'(PacY), 8);

    frame("idle", 0, 312, 232, 32'(DIR_NONE), 1'b0, 1'b1);

    press(KEY_LEFT);
    for (int k = 0; k < 312; k++) begin
      pulse("walk", 1'b0, got, nz);
      if (got != 21) begin
        check("walk_lat", got, 21);
        break;
      end
    end
    check("walk_posx", 32'(PosX), 0);
    check("walk_dir", 32'(cur_dir), 32'(DIR_LEFT));
    frame("edge", 21, 0, 232, 32'(DIR_NONE), 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
